qam_demapper: RTL and testbench

Receive-side symbol recovery for the QAM-16 chain. Accepts the demodulated signed baseband stream (`demult_i` / `demult_q`) produced by `qam_top` and integrates each rail over one symbol period (integrate-and-dump). It then slices each rail to one of four levels and demaps the pair back to the 4-bit symbol originally presented on `din`. Recovered symbols leave through a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake.

---
 rtl/qam_demapper_if.sv | 22 ++
 rtl/qam_demapper.sv | 173 +++++++++++++++++
 tb/tb_qam_demapper.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_demapper_if.sv
// qam_demapper_if: sample stream in, recovered symbol stream out.
// The slave side is the demapper; the master side feeds samples and
// consumes symbols.
interface qam_demapper_if;
  logic               demult_valid;
  logic signed [19:0] demult_i;
  logic signed [19:0] demult_q;
  logic               dout_valid;
  logic [3:0]         dout;
  logic               dout_ready;
  logic               overflow;

  modport master (
    output demult_valid, demult_i, demult_q, dout_ready,
    input  dout_valid, dout, overflow
  );

  modport slave (
    input  demult_valid, demult_i, demult_q, dout_ready,
    output dout_valid, dout, overflow
  );
endinterface

// File: rtl/qam_demapper.sv
// qam_demapper: QAM-16 receive symbol recovery.
// Integrate-and-dump over 2^SPS_LOG2 valid samples per rail, four-level
// slicing, demapping to a 4-bit symbol, and a FWFT output FIFO with a
// sticky overflow flag.
// Build option: define QAM_DEMAP_GRAY_EN for Gray-coded levels; otherwise
// levels map to natural binary.
module qam_demapper #(
  parameter int SPS_LOG2   = 4,
  parameter int SKIP       = 0,
  parameter int THRESH     = 262144,
  parameter int FIFO_DEPTH = 4
) (
  input logic           axi_clk,
  input logic           axi_rstn,
  qam_demapper_if.slave bus
);

  localparam int ACC_W = 20 + SPS_LOG2;
  localparam int SPS   = 1 << SPS_LOG2;
  localparam int CNT_W = (SPS_LOG2 > 0) ? SPS_LOG2 : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic signed [ACC_W-1:0] THRESH_POS = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THRESH_NEG = -THRESH_POS;
  localparam logic [CNT_W-1:0]        LAST_SAMP  = CNT_W'(SPS - 1);
  localparam logic [15:0]             LAST_SKIP  = (SKIP > 0) ? 16'(SKIP - 1) : 16'd0;
  localparam bit                      NO_SKIP    = (SKIP == 0);
  localparam logic [AW:0]             FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

`ifdef QAM_DEMAP_GRAY_EN
  localparam logic [1:0] CODE_M3 = 2'b00;
  localparam logic [1:0] CODE_M1 = 2'b01;
  localparam logic [1:0] CODE_P1 = 2'b11;
  localparam logic [1:0] CODE_P3 = 2'b10;
`else
  localparam logic [1:0] CODE_M3 = 2'b00;
  localparam logic [1:0] CODE_M1 = 2'b01;
  localparam logic [1:0] CODE_P1 = 2'b10;
  localparam logic [1:0] CODE_P3 = 2'b11;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACCUM
  } state_t;

  state_t                   state;
  logic [15:0]              skip_cnt;
  logic [CNT_W-1:0]         samp_cnt;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     sym_valid;
  logic [3:0]               sym_code;

  logic signed [ACC_W-1:0]  samp_i;
  logic signed [ACC_W-1:0]  samp_q;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     accept;
  logic                     last_samp;

  logic [3:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              count;
  logic                     full;
  logic                     pop;
  logic                     do_write;
  logic                     overflow_r;

  // Four-level decision on a completed symbol sum.
  function automatic logic [1:0] slice_rail(input logic signed [ACC_W-1:0] s);
    if (s < THRESH_NEG)      return CODE_M3;
    else if (s[ACC_W-1])     return CODE_M1;
    else if (s < THRESH_POS) return CODE_P1;
    else                     return CODE_P3;
  endfunction

  // Sign-extend the incoming samples and form the running sums; a sample is
  // integrated in ACCUM, or straight out of IDLE when no skip is configured.
  always_comb begin
    samp_i    = ACC_W'(bus.demult_i);
    samp_q    = ACC_W'(bus.demult_q);
    sum_i     = acc_i + samp_i;
    sum_q     = acc_q + samp_q;
    accept    = bus.demult_valid &&
                ((state == ST_ACCUM) || ((state == ST_IDLE) && NO_SKIP));
    last_samp = (samp_cnt == LAST_SAMP);
  end

  // Sequencer: skip alignment, integrate-and-dump, and registered slicing
  // of each completed symbol.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      samp_cnt  <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sym_valid <= 1'b0;
      sym_code  <= '0;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_SKIP: begin
          if (bus.demult_valid) begin
            if (NO_SKIP) begin
              state <= ST_ACCUM;
            end else begin
              skip_cnt <= skip_cnt + 16'd1;
              state    <= (skip_cnt == LAST_SKIP) ? ST_ACCUM : ST_SKIP;
            end
          end
        end
        ST_ACCUM: begin
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        if (last_samp) begin
          sym_code  <= {slice_rail(sum_i), slice_rail(sum_q)};
          sym_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          samp_cnt  <= '0;
        end else begin
          acc_i     <= sum_i;
          acc_q     <= sum_q;
          samp_cnt  <= samp_cnt + 1'b1;
        end
      end
    end
  end

  // FIFO control: a push into a full FIFO is dropped unless a pop frees the
  // slot in the same cycle.
  always_comb begin
    full     = (count == FULL_CNT);
    pop      = (count != '0) && bus.dout_ready;
    do_write = sym_valid && (!full || pop);
  end

  // Symbol storage; contents are only meaningful between the pointers.
  always_ff @(posedge axi_clk) begin
    if (do_write) mem[wr_ptr] <= sym_code;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sym_valid && full && !pop) overflow_r <= 1'b1;
    end
  end

  assign bus.dout_valid = (count != '0);
  assign bus.dout       = (count != '0) ? mem[rd_ptr] : 4'd0;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_qam_demapper.sv
// tb_qam_demapper: directed and randomized checks of qam_demapper against a
// sum-and-threshold reference model. A second instance with SKIP=3 shares
// the sample stream to exercise skip alignment.
module tb_qam_demapper;

  localparam int THRESH = 262144;
  localparam int SPS    = 16;

  logic axi_clk  = 1'b0;
  logic axi_rstn = 1'b0;

  qam_demapper_if bus ();
  qam_demapper_if bus2 ();

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] exp_q [$];
  logic [3:0] cc;
  logic [3:0] exp_head;
  logic       rv;
  logic       rr;
  int         ri;
  int         rq;
  int         acc_i;
  int         acc_q;
  int         n_samp;

  qam_demapper #(
    .SPS_LOG2(4), .SKIP(0), .THRESH(THRESH), .FIFO_DEPTH(4)
  ) dut (
    .axi_clk (axi_clk),
    .axi_rstn(axi_rstn),
    .bus     (bus.slave)
  );

  qam_demapper #(
    .SPS_LOG2(4), .SKIP(3), .THRESH(THRESH), .FIFO_DEPTH(4)
  ) dut_skip (
    .axi_clk (axi_clk),
    .axi_rstn(axi_rstn),
    .bus     (bus2.slave)
  );

  assign bus2.demult_valid = bus.demult_valid;
  assign bus2.demult_i     = bus.demult_i;
  assign bus2.demult_q     = bus.demult_q;
  assign bus2.dout_ready   = 1'b1;

  always #5 axi_clk = ~axi_clk;

  // Reference: level of a full-symbol sum, then the level's 2-bit code.
  function automatic logic [1:0] level_code(input int s);
    int idx;
    if (s < -THRESH)     idx = 0;
    else if (s < 0)      idx = 1;
    else if (s < THRESH) idx = 2;
    else                 idx = 3;
`ifdef QAM_DEMAP_GRAY_EN
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
`else
    return 2'(idx);
`endif
  endfunction

  function automatic logic [3:0] ref_symbol(input int sum_i, input int sum_q);
    return {level_code(sum_i), level_code(sum_q)};
  endfunction

  function automatic int amp_of_level(input int k);
    case (k)
      0:       return -30000;
      1:       return -5000;
      2:       return 5000;
      default: return 30000;
    endcase
  endfunction

  // Constant per-sample amplitude whose symbol sum slices to the given code.
  function automatic int amp_for_code(input logic [1:0] code);
    for (int k = 0; k < 4; k++)
      if (level_code(SPS * amp_of_level(k)) == code) return amp_of_level(k);
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int i, input int q);
    bus.demult_valid = v;
    bus.demult_i     = 20'(i);
    bus.demult_q     = 20'(q);
    @(posedge axi_clk);
    #1;
  endtask

  task automatic feed_symbol(input int i, input int q);
    repeat (SPS) applyStimulus(1'b1, i, q);
    bus.demult_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.demult_valid = 1'b0;
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  initial begin
    bus.demult_valid = 1'b0;
    bus.demult_i     = '0;
    bus.demult_q     = '0;
    bus.dout_ready   = 1'b1;

    // Reset state
    repeat (2) @(posedge axi_clk);
    #1;
    checkOutput("rst_dout_valid", bus.dout_valid, 0);
    checkOutput("rst_dout", bus.dout, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    axi_rstn = 1'b1;
    idle_cycles(2);

    // Basic symbol and two-edge latency
    feed_symbol(30000, -5000);
    checkOutput("t1_not_early", bus.dout_valid, 0);
    idle_cycles(1);
    checkOutput("t1_valid", bus.dout_valid, 1);
    checkOutput("t1_dout", bus.dout, ref_symbol(480000, -80000));
    idle_cycles(1);
    checkOutput("t1_popped", bus.dout_valid, 0);

    // Threshold boundaries: 0 and exactly -THRESH
    feed_symbol(0, -16384);
    idle_cycles(1);
    checkOutput("t2_valid", bus.dout_valid, 1);
    checkOutput("t2_dout", bus.dout, ref_symbol(0, -262144));
    idle_cycles(1);

    // Alternating valid: one symbol after 16 valid samples only
    for (int k = 0; k < 32; k++) begin
      applyStimulus((k % 2) == 0, -20000, 20000);
      if (k < 31) checkOutput("t3_no_early", bus.dout_valid, 0);
    end
    checkOutput("t3_valid", bus.dout_valid, 1);
    checkOutput("t3_dout", bus.dout, ref_symbol(-320000, 320000));
    idle_cycles(1);

    // Backpressure, fill, drop and in-order drain
    bus.dout_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cc = 4'(c);
      feed_symbol(amp_for_code(cc[3:2]), amp_for_code(cc[1:0]));
    end
    idle_cycles(1);
    checkOutput("t4_full_no_ovf", bus.overflow, 0);
    checkOutput("t4_head_valid", bus.dout_valid, 1);
    checkOutput("t4_head", bus.dout, 0);
    cc = 4'd4;
    feed_symbol(amp_for_code(cc[3:2]), amp_for_code(cc[1:0]));
    checkOutput("t4_ovf_not_yet", bus.overflow, 0);
    idle_cycles(1);
    checkOutput("t4_ovf_set", bus.overflow, 1);
    checkOutput("t4_head_stable", bus.dout, 0);
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checkOutput("t4_drain_valid", bus.dout_valid, 1);
      checkOutput("t4_drain_dout", bus.dout, c);
      idle_cycles(1);
    end
    checkOutput("t4_drained", bus.dout_valid, 0);
    checkOutput("t4_ovf_sticky", bus.overflow, 1);

    // Asynchronous reset mid-symbol
    bus.dout_ready = 1'b0;
    feed_symbol(30000, 30000);
    idle_cycles(1);
    repeat (8) applyStimulus(1'b1, 30000, 30000);
    bus.demult_valid = 1'b0;
    #2;
    axi_rstn = 1'b0;
    #1;
    checkOutput("t5_rst_valid", bus.dout_valid, 0);
    checkOutput("t5_rst_ovf", bus.overflow, 0);
    #2;
    axi_rstn = 1'b1;
    @(posedge axi_clk);
    #1;
    bus.dout_ready = 1'b1;
    feed_symbol(-30000, -5000);
    idle_cycles(1);
    checkOutput("t5_after_valid", bus.dout_valid, 1);
    checkOutput("t5_after_dout", bus.dout, ref_symbol(-480000, -80000));
    idle_cycles(1);

    // Randomized traffic against a scoreboard queue
    acc_i  = 0;
    acc_q  = 0;
    n_samp = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      rv = ($urandom_range(0, 3) != 0);
      ri = int'($urandom_range(0, 60000)) - 30000;
      rq = int'($urandom_range(0, 60000)) - 30000;
      rr = ((cyc % 4) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.dout_ready = rr;
      if (bus.dout_valid && rr) begin
        exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
        checkOutput("rand_sym", {bus.dout_valid, bus.dout}, {1'b1, exp_head});
      end
      if (rv) begin
        acc_i += ri;
        acc_q += rq;
        n_samp++;
        if (n_samp == SPS) begin
          exp_q.push_back(ref_symbol(acc_i, acc_q));
          acc_i  = 0;
          acc_q  = 0;
          n_samp = 0;
        end
      end
      applyStimulus(rv, ri, rq);
    end
    bus.demult_valid = 1'b0;
    bus.dout_ready   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() > 0 && bus.dout_valid) begin
        exp_head = exp_q.pop_front();
        checkOutput("rand_drain", bus.dout, exp_head);
      end
      idle_cycles(1);
    end
    checkOutput("rand_all_seen", exp_q.size(), 0);
    checkOutput("rand_empty", bus.dout_valid, 0);
    checkOutput("rand_no_ovf", bus.overflow, 0);

    // SKIP=3 instance: first three samples discarded
    #2;
    axi_rstn = 1'b0;
    #3;
    axi_rstn = 1'b1;
    @(posedge axi_clk);
    #1;
    repeat (3) applyStimulus(1'b1, -30000, -30000);
    for (int k = 0; k < SPS; k++) begin
      applyStimulus(1'b1, 30000, 30000);
      checkOutput("t6_no_early", bus2.dout_valid, 0);
    end
    idle_cycles(1);
    checkOutput("t6_valid", bus2.dout_valid, 1);
    checkOutput("t6_dout", bus2.dout, ref_symbol(480000, 480000));
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
